// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around an external combinational ALU: holds the register file,
// accepts one instruction at a time, registers ALU operands and returns the captured result.
module alu_issue_wb #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [REG_AW-1:0] in_rs1,
  input  logic [REG_AW-1:0] in_rs2,
  input  logic              in_imm_en,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [REG_AW-1:0] res_rd,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
  // The producer holds its payload stable while valid=1 and ready=0.
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state;
  logic [DATA_W-1:0] regs [NREGS];
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;

  // r0 is never written, but reads are forced to zero so that invariant is explicit
  assign rs1_val  = (in_rs1 == '0) ? '0 : regs[in_rs1];
  assign rs2_val  = (in_rs2 == '0) ? '0 : regs[in_rs2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  assign in_ready  = rst_n && (state == IDLE);
  assign res_valid = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sel  <= '0;
      res_data <= '0;
      res_rd   <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            alu_a   <= rs1_val;
            alu_b   <= in_imm_en ? in_imm : rs2_val;
            alu_sel <= in_op;
            res_rd  <= in_rd;
            state   <= EXEC;
          end
        end
        EXEC: begin
          // Writeback lands here so the next accepted instruction already sees it
          res_data <= alu_out;
          if (res_rd != '0) regs[res_rd] <= alu_out;
          state <= RESP;
        end
        RESP: begin
          if (res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Randomized and directed bench for alu_issue_wb with a behavioural ALU and register-file model.
module tb_alu_issue_wb;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [2:0]  in_rd;
  logic [2:0]  in_rs1;
  logic [2:0]  in_rs2;
  logic        in_imm_en;
  logic [15:0] in_imm;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [1:0]  alu_sel;
  logic [15:0] alu_out;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic [2:0]  res_rd;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_issue_wb #(.DATA_W(16), .NREGS(8), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rd(in_rd),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_rd(res_rd),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- reference models ----------------
  function automatic logic [15:0] alu_ref(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    int unsigned r;
    case (op)
      2'd0:    r = (int'(a) + int'(b)) % 65536;
      2'd1:    r = (int'(a) - int'(b) + 65536) % 65536;
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    return r[15:0];
  endfunction

  assign alu_out = alu_ref(alu_sel, alu_a, alu_b);

  logic [15:0] model_regs [8];
  logic [15:0] exp_q [$];

  int tests  = 0;
  int errors = 0;
  int acc_cyc = 0;
  int prev_acc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_instr(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic imm_en, input logic [15:0] imm,
                          input int stall, input string tag);
    logic [15:0] ea, eb, er, popped;
    @(negedge clk);
    check_eq({tag, "_in_ready_idle"}, in_ready, 1);
    check_eq({tag, "_res_valid_idle"}, res_valid, 0);
    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_imm_en = imm_en; in_imm = imm;
    ea = model_regs[rs1];
    eb = imm_en ? imm : model_regs[rs2];
    er = alu_ref(op, ea, eb);
    exp_q.push_back(er);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    prev_acc = acc_cyc;
    acc_cyc = cyc;
    @(negedge clk);
    check_eq({tag, "_in_ready_exec"}, in_ready, 0);
    check_eq({tag, "_res_valid_exec"}, res_valid, 0);
    check_eq({tag, "_alu_a"}, alu_a, ea);
    check_eq({tag, "_alu_b"}, alu_b, eb);
    check_eq({tag, "_alu_sel"}, alu_sel, op);
    res_ready = (stall == 0);
    dbg_addr = rd;
    if (rd != 3'd0) model_regs[rd] = er;
    @(posedge clk);
    @(negedge clk);
    popped = exp_q.pop_front();
    check_eq({tag, "_res_valid"}, res_valid, 1);
    check_eq({tag, "_res_data"}, res_data, popped);
    check_eq({tag, "_res_rd"}, res_rd, rd);
    check_eq({tag, "_dbg_wb"}, dbg_data, model_regs[rd]);
    for (int s = 0; s < stall; s++) begin
      // Junk instruction offered while stalled must be ignored
      in_valid = 1'b1; in_rd = 3'd6; in_rs1 = 3'd0; in_imm_en = 1'b1; in_imm = 16'hBEEF; in_op = 2'd0;
      @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_stall_valid"}, res_valid, 1);
      check_eq({tag, "_stall_data"}, res_data, popped);
      check_eq({tag, "_stall_rd"}, res_rd, rd);
      check_eq({tag, "_stall_ready"}, in_ready, 0);
      check_eq({tag, "_stall_alu_a"}, alu_a, ea);
      if (s == stall - 1) begin
        in_valid = 1'b0;
        res_ready = 1'b1;
      end
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0];
      #1;
      check_eq($sformatf("%s_r%0d", tag, i), dbg_data, model_regs[i]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm_en = 1'b0; in_imm = '0; res_ready = 1'b1; dbg_addr = '0;
    for (int i = 0; i < 8; i++) model_regs[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_res_valid", res_valid, 0);
    check_eq("rst_alu_a", alu_a, 0);
    check_eq("rst_alu_b", alu_b, 0);
    check_eq("rst_alu_sel", alu_sel, 0);
    check_eq("rst_res_data", res_data, 0);
    check_eq("rst_res_rd", res_rd, 0);
    rst_n = 1'b1;
    check_all_regs("rst");

    // 1: first op right after reset
    do_instr(2'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h00FA, 0, "t1");
    // 2: dependent back-to-back, accepts three cycles apart
    do_instr(2'd0, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0002, 0, "t2a");
    do_instr(2'd1, 3'd3, 3'd2, 3'd1, 1'b0, 16'h0000, 0, "t2b");
    check_eq("t2_accept_spacing", acc_cyc - prev_acc, 3);
    // 3: wrap-around and r0 writes
    do_instr(2'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'hFFFF, 0, "t3a");
    do_instr(2'd0, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0001, 0, "t3b");
    do_instr(2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234, 0, "t3c");
    check_all_regs("t3");
    // 4: backpressure for 5 cycles with junk offered
    do_instr(2'd3, 3'd5, 3'd1, 3'd4, 1'b0, 16'h0000, 5, "t4");
    @(negedge clk);
    check_eq("t4_back_idle", res_valid, 0);
    check_eq("t4_idle_ready", in_ready, 1);
    check_all_regs("t4");

    // 5: reset while in EXEC
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd3; in_rd = 3'd5; in_rs1 = 3'd0; in_imm_en = 1'b1; in_imm = 16'h00F0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", res_valid, 0);
    check_eq("t5_rst_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check_eq("t5_hold_valid", res_valid, 0);
    check_eq("t5_hold_ready", in_ready, 0);
    for (int i = 0; i < 8; i++) model_regs[i] = '0;
    rst_n = 1'b1;
    check_all_regs("t5");

    // 6: all selects on 0x00FA and 0x0002
    do_instr(2'd0, 3'd1, 3'd0, 3'd0, 1'b1, 16'h00FA, 0, "t6_set");
    for (int s = 0; s < 4; s++)
      do_instr(s[1:0], 3'd7, 3'd1, 3'd0, 1'b1, 16'h0002, 0, $sformatf("t6_sel%0d", s));

    // Random traffic
    for (int k = 0; k < 30; k++)
      do_instr(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
               $urandom_range(0, 2), $sformatf("rnd%0d", k));
    @(negedge clk);
    check_all_regs("final");
    check_eq("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
